jtag_scan_master: RTL and testbench

- Host-side initiator for the two-wire-plus-mode JTAG debug link: the other end of the debug module's virtual-JTAG TAP.
- Generates TCK/TMS/TDI from the system clock and walks the IEEE 1149.1 TAP state machine.
- Shifts an optional IR instruction and then a DR word into the target, capturing TDO on the way through.
- Used by on-chip test/bring-up logic to drive the debug module's 2-bit IR / 38-bit DR scan chain without an external cable.

---
 rtl/jtag_scan_master.sv | 182 ++++++++++++++++++
 tb/tb_jtag_scan_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_master.sv
// Host-side JTAG scan initiator: derives TCK/TMS/TDI from clk, walks the TAP through an
// optional IR shift and a DR shift (or a TAP reset), and captures TDO on the way.
module jtag_scan_master #(
    parameter int IR_WIDTH = 2,
    parameter int DR_WIDTH = 38,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                skip_ir,
    input  logic                tap_reset,
    input  logic [IR_WIDTH-1:0] ir_in,
    input  logic [DR_WIDTH-1:0] dr_in,
    output logic                busy,
    output logic                done,
    output logic [IR_WIDTH-1:0] ir_cap,
    output logic [DR_WIDTH-1:0] dr_out,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);

    localparam int N_FULL = 10 + IR_WIDTH + DR_WIDTH;
    localparam int IW     = $clog2(N_FULL + 1);
    localparam int CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef logic [IW-1:0] idx_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DIV_LAST = cnt_t'(CLK_DIV - 1);

    // TCK indices of the landmarks in each sequence (index 0 is the first TCK).
    localparam idx_t F_IR_FIRST = idx_t'(4);
    localparam idx_t F_IR_LAST  = idx_t'(3 + IR_WIDTH);
    localparam idx_t F_SEL_DR   = idx_t'(5 + IR_WIDTH);
    localparam idx_t F_DR_FIRST = idx_t'(8 + IR_WIDTH);
    localparam idx_t F_DR_LAST  = idx_t'(7 + IR_WIDTH + DR_WIDTH);
    localparam idx_t F_END      = idx_t'(9 + IR_WIDTH + DR_WIDTH);
    localparam idx_t S_DR_FIRST = idx_t'(3);
    localparam idx_t S_DR_LAST  = idx_t'(2 + DR_WIDTH);
    localparam idx_t S_END      = idx_t'(4 + DR_WIDTH);
    localparam idx_t R_END      = idx_t'(5);

    typedef enum logic [1:0] {MODE_FULL, MODE_DR, MODE_RST} mode_t;
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH} state_t;

    state_t state, state_d;
    mode_t  mode;
    idx_t   seq_idx, drive_idx;
    cnt_t   div_cnt;
    logic   accept, drive, rise, finish;
    logic [IR_WIDTH-1:0] ir_sh;
    logic [DR_WIDTH-1:0] dr_sh;

    function automatic logic tms_at(mode_t m, idx_t i);
        case (m)
            MODE_RST: return i < R_END;
            MODE_DR:  return (i == '0) || (i >= S_DR_LAST && i < S_END);
            default:  return (i <= idx_t'(1)) || (i >= F_IR_LAST && i <= F_SEL_DR) ||
                             (i >= F_DR_LAST && i < F_END);
        endcase
    endfunction

    function automatic logic ir_shift_at(mode_t m, idx_t i);
        return (m == MODE_FULL) && (i >= F_IR_FIRST) && (i <= F_IR_LAST);
    endfunction

    function automatic logic dr_shift_at(mode_t m, idx_t i);
        case (m)
            MODE_FULL: return (i >= F_DR_FIRST) && (i <= F_DR_LAST);
            MODE_DR:   return (i >= S_DR_FIRST) && (i <= S_DR_LAST);
            default:   return 1'b0;
        endcase
    endfunction

    function automatic idx_t last_idx(mode_t m);
        case (m)
            MODE_RST: return R_END;
            MODE_DR:  return S_END;
            default:  return F_END;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_d;
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        drive   = 1'b0;
        rise    = 1'b0;
        finish  = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                accept  = 1'b1;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                drive   = 1'b1;
                state_d = S_LOW;
            end
            S_LOW: if (div_cnt == DIV_LAST) begin
                rise    = 1'b1;
                state_d = S_HIGH;
            end
            S_HIGH: if (div_cnt == DIV_LAST) begin
                if (seq_idx == last_idx(mode)) begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    drive   = 1'b1;
                    state_d = S_LOW;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The setup cycle after acceptance aligns the final TCK fall with the done edge.
    assign drive_idx = (state == S_SETUP) ? '0 : seq_idx + idx_t'(1);
    assign busy      = (state != S_IDLE);

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tck     <= 1'b0;
            tms     <= 1'b1;
            tdi     <= 1'b0;
            done    <= 1'b0;
            ir_cap  <= '0;
            dr_out  <= '0;
            seq_idx <= '0;
            div_cnt <= '0;
            mode    <= MODE_FULL;
            ir_sh   <= '0;
            dr_sh   <= '0;
        end else begin
            done <= finish;
            if (accept) begin
                mode  <= tap_reset ? MODE_RST : (skip_ir ? MODE_DR : MODE_FULL);
                ir_sh <= ir_in;
                dr_sh <= dr_in;
            end
            if (drive) begin
                seq_idx <= drive_idx;
                div_cnt <= '0;
                tck     <= 1'b0;
                tms     <= tms_at(mode, drive_idx);
                if (ir_shift_at(mode, drive_idx)) begin
                    tdi   <= ir_sh[0];
                    ir_sh <= ir_sh >> 1;
                end else if (dr_shift_at(mode, drive_idx)) begin
                    tdi   <= dr_sh[0];
                    dr_sh <= dr_sh >> 1;
                end else begin
                    tdi <= 1'b0;
                end
            end else if (rise) begin
                div_cnt <= '0;
                tck     <= 1'b1;
                // Captured bits enter at the MSB so bit k lands at index k after the last shift.
                if (ir_shift_at(mode, seq_idx))
                    ir_cap <= IR_WIDTH'({tdo, ir_cap} >> 1);
                else if (dr_shift_at(mode, seq_idx))
                    dr_out <= DR_WIDTH'({tdo, dr_out} >> 1);
            end else if (finish) begin
                div_cnt <= '0;
                tck     <= 1'b0;
                tms     <= 1'b0;
                tdi     <= 1'b0;
            end else if (state == S_LOW || state == S_HIGH) begin
                div_cnt <= div_cnt + cnt_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master: a CLK_DIV=2 instance with loopback/forced TDO and a
// CLK_DIV=1 instance driving a behavioural TAP target.
module tb_jtag_scan_master;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_t;

    localparam logic [37:0] PATTERN  = 38'h3F_0000_FFFF;
    localparam logic [63:0] FULL_TMS = 64'({4'b1100, 2'b01, 4'b1100, 37'b0, 1'b1, 2'b10});
    localparam logic [63:0] DR_TMS   = 64'({3'b100, 37'b0, 1'b1, 2'b10});
    localparam logic [63:0] RST_TMS  = 64'(6'b111110);

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0, skip_ir = 1'b0, tap_reset = 1'b0;
    logic [1:0]  ir_in = '0;
    logic [37:0] dr_in = '0;
    logic        tdo_hold = 1'b0;

    logic        busy_a, done_a, tck_a, tms_a, tdi_a, tdo_a;
    logic [1:0]  ir_cap_a;
    logic [37:0] dr_out_a;
    logic        busy_b, done_b, tck_b, tms_b, tdi_b;
    logic        tdo_b = 1'b0;
    logic [1:0]  ir_cap_b;
    logic [37:0] dr_out_b;

    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    assign tdo_a = tdo_hold ? 1'b1 : tdi_a;

    jtag_scan_master #(.IR_WIDTH(2), .DR_WIDTH(38), .CLK_DIV(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .skip_ir(skip_ir), .tap_reset(tap_reset),
        .ir_in(ir_in), .dr_in(dr_in), .busy(busy_a), .done(done_a), .ir_cap(ir_cap_a),
        .dr_out(dr_out_a), .tck(tck_a), .tms(tms_a), .tdi(tdi_a), .tdo(tdo_a)
    );

    jtag_scan_master #(.IR_WIDTH(2), .DR_WIDTH(38), .CLK_DIV(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .skip_ir(skip_ir), .tap_reset(tap_reset),
        .ir_in(ir_in), .dr_in(dr_in), .busy(busy_b), .done(done_b), .ir_cap(ir_cap_b),
        .dr_out(dr_out_b), .tck(tck_b), .tms(tms_b), .tdi(tdi_b), .tdo(tdo_b)
    );

    // Instance under test for the generic scan task.
    logic sel = 1'b0;
    logic mtck, mtms, mdone, mbusy;
    assign mtck  = sel ? tck_b  : tck_a;
    assign mtms  = sel ? tms_b  : tms_a;
    assign mdone = sel ? done_b : done_a;
    assign mbusy = sel ? busy_b : busy_a;

    int          npulse = 0, done_cnt = 0, viol = 0;
    logic [63:0] trace = '0;
    logic        prev_tms_b = 1'b1, prev_tdi_b = 1'b0;

    always @(posedge mtck) begin
        npulse <= npulse + 1;
        trace  <= {trace[62:0], mtms};
    end

    always @(posedge clk) if (mdone) done_cnt <= done_cnt + 1;

    // tms/tdi must never move while tck is high (CLK_DIV=1 instance).
    always @(negedge clk) begin
        if (tck_b === 1'b1 && (tms_b !== prev_tms_b || tdi_b !== prev_tdi_b)) viol <= viol + 1;
        prev_tms_b <= tms_b;
        prev_tdi_b <= tdi_b;
    end

    // Behavioural TAP target: IEEE 1149.1 state walk, capture IR=01, DR=PATTERN, tdo on tck fall.
    tap_t        tap_st = RTI;
    logic [1:0]  t_ir_sr = '0, t_ir_reg = '0;
    logic [37:0] t_dr_sr = '0, t_dr_reg = '0;

    function automatic tap_t tap_next(tap_t s, logic m);
        case (s)
            TLR:    return m ? TLR    : RTI;
            RTI:    return m ? SEL_DR : RTI;
            SEL_DR: return m ? SEL_IR : CAP_DR;
            CAP_DR: return m ? EX1_DR : SH_DR;
            SH_DR:  return m ? EX1_DR : SH_DR;
            EX1_DR: return m ? UPD_DR : PAU_DR;
            PAU_DR: return m ? EX2_DR : PAU_DR;
            EX2_DR: return m ? UPD_DR : SH_DR;
            UPD_DR: return m ? SEL_DR : RTI;
            SEL_IR: return m ? TLR    : CAP_IR;
            CAP_IR: return m ? EX1_IR : SH_IR;
            SH_IR:  return m ? EX1_IR : SH_IR;
            EX1_IR: return m ? UPD_IR : PAU_IR;
            PAU_IR: return m ? EX2_IR : PAU_IR;
            EX2_IR: return m ? UPD_IR : SH_IR;
            default: return m ? SEL_DR : RTI;
        endcase
    endfunction

    always @(posedge tck_b) begin
        case (tap_st)
            CAP_IR:  t_ir_sr  <= 2'b01;
            SH_IR:   t_ir_sr  <= {tdi_b, t_ir_sr[1]};
            UPD_IR:  t_ir_reg <= t_ir_sr;
            CAP_DR:  t_dr_sr  <= PATTERN;
            SH_DR:   t_dr_sr  <= {tdi_b, t_dr_sr[37:1]};
            UPD_DR:  t_dr_reg <= t_dr_sr;
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms_b);
    end

    always @(negedge tck_b)
        tdo_b <= (tap_st == SH_IR) ? t_ir_sr[0] : ((tap_st == SH_DR) ? t_dr_sr[0] : 1'b0);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mask(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    // One scan on the selected instance; lat counts clk edges from acceptance to done.
    task automatic run_scan(input logic sk, input logic rs, input logic [1:0] ir,
                            input logic [37:0] dr, input int inject_at,
                            output int lat, output int pulses, output logic [63:0] tms_tr,
                            output logic busy_after, output logic done_next);
        int p0;
        @(negedge clk);
        skip_ir   = sk;
        tap_reset = rs;
        ir_in     = ir;
        dr_in     = dr;
        p0        = npulse;
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);
        busy_after = mbusy;
        skip_ir    = ~sk;
        tap_reset  = ~rs;
        ir_in      = ~ir;
        dr_in      = ~dr;
        lat = 0;
        while (lat < 3000) begin
            @(posedge clk);
            lat++;
            #1;
            if (mdone) break;
            if (lat == inject_at) begin
                dr_in = 38'h30_0000_0001;
                set_start(1'b1);
            end else begin
                set_start(1'b0);
            end
        end
        set_start(1'b0);
        pulses = npulse - p0;
        tms_tr = trace;
        @(posedge clk);
        #1;
        done_next = mdone;
    endtask

    int          lat, pul, d0;
    logic [63:0] tr;
    logic        bz, dn;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl_a", {tck_a, tms_a, tdi_a, busy_a, done_a}, 5'b01000);
        check("rst_ir_cap", ir_cap_a, 0);
        check("rst_dr_out", dr_out_a, 0);
        check("rst_ctl_b", {tck_b, tms_b, busy_b}, 3'b010);
        @(negedge clk);
        reset_n = 1'b1;

        // Full scan with TDO looped back to TDI.
        run_scan(1'b0, 1'b0, 2'b10, 38'h2A_5A5A_5A5A, 0, lat, pul, tr, bz, dn);
        check("full_lat", lat, 201);
        check("full_busy", bz, 1);
        check("full_tck", pul, 50);
        check("full_tms", tr & mask(50), FULL_TMS);
        check("full_dr_out", dr_out_a, 38'h2A_5A5A_5A5A);
        check("full_ir_cap", ir_cap_a, 2'b10);
        check("full_done_width", dn, 0);
        check("full_idle", {tck_a, tms_a, busy_a}, 3'b000);

        // DR-only scan with TDO held high.
        tdo_hold = 1'b1;
        run_scan(1'b1, 1'b0, 2'b01, 38'h0, 0, lat, pul, tr, bz, dn);
        check("dr_lat", lat, 173);
        check("dr_tck", pul, 43);
        check("dr_tms", tr & mask(43), DR_TMS);
        check("dr_dr_out", dr_out_a, 38'h3F_FFFF_FFFF);
        check("dr_ir_cap", ir_cap_a, 2'b10);

        // TAP reset sequence.
        tdo_hold = 1'b0;
        run_scan(1'b1, 1'b1, 2'b01, 38'h1, 0, lat, pul, tr, bz, dn);
        check("rst_seq_lat", lat, 25);
        check("rst_seq_tck", pul, 6);
        check("rst_seq_tms", tr & mask(6), RST_TMS);
        check("rst_seq_dr_out", dr_out_a, 38'h3F_FFFF_FFFF);
        check("rst_seq_ir_cap", ir_cap_a, 2'b10);

        // Start while busy is ignored.
        d0 = done_cnt;
        run_scan(1'b0, 1'b0, 2'b01, 38'h0F_1234_5678, 10, lat, pul, tr, bz, dn);
        repeat (8) @(posedge clk);
        #1;
        check("busy_lat", lat, 201);
        check("busy_dr_out", dr_out_a, 38'h0F_1234_5678);
        check("busy_ir_cap", ir_cap_a, 2'b01);
        check("busy_done_cnt", done_cnt - d0, 1);
        check("busy_not_queued", busy_a, 0);

        // Reset during Shift-DR bit 20 (TCK index 30, low phase from accept+121).
        d0 = done_cnt;
        @(negedge clk);
        skip_ir   = 1'b0;
        tap_reset = 1'b0;
        ir_in     = 2'b11;
        dr_in     = 38'h15_A5A5_A5A5;
        start_a   = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (122) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ctl", {tck_a, tms_a, busy_a, done_a}, 4'b0100);
        check("abort_dr_out", dr_out_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        run_scan(1'b0, 1'b0, 2'b11, 38'h15_A5A5_A5A5, 0, lat, pul, tr, bz, dn);
        check("after_abort_lat", lat, 201);
        check("after_abort_dr_out", dr_out_a, 38'h15_A5A5_A5A5);
        check("after_abort_ir_cap", ir_cap_a, 2'b11);

        // CLK_DIV=1 against the behavioural target.
        sel = 1'b1;
        run_scan(1'b0, 1'b0, 2'b10, 38'h12_3456_789A, 0, lat, pul, tr, bz, dn);
        check("edge_lat", lat, 101);
        check("edge_tck", pul, 50);
        check("edge_tms", tr & mask(50), FULL_TMS);
        check("edge_dr_out", dr_out_b, PATTERN);
        check("edge_ir_cap", ir_cap_b, 2'b01);
        check("edge_tgt_ir", t_ir_reg, 2'b10);
        check("edge_tgt_dr", t_dr_reg, 38'h12_3456_789A);
        check("edge_tgt_state", tap_st, RTI);
        check("edge_tms_tdi_stable", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
